// File: rtl/mc_sdp_bram_if.sv
// Request/response bus of the multi-channel simple dual-port block RAM.
// master drives write/read requests and dout_ready; slave is the RAM side.
interface mc_sdp_bram_if #(
    parameter int unsigned RAM_WIDTH  = 128,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_DEPTH   = 16
);
    localparam int unsigned NB   = RAM_WIDTH / BYTE_WIDTH;
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned AD_W = $clog2(CH_DEPTH);

    logic                 wr_valid;
    logic [CH_W-1:0]      wr_ch;
    logic [AD_W-1:0]      wr_addr;
    logic [NB-1:0]        wr_be;
    logic [RAM_WIDTH-1:0] wr_data;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [CH_W-1:0]      rd_ch;
    logic [AD_W-1:0]      rd_addr;

    logic                 dout_valid;
    logic                 dout_ready;
    logic [CH_W-1:0]      dout_ch;
    logic [RAM_WIDTH-1:0] dout_data;

    modport master (
        output wr_valid, wr_ch, wr_addr, wr_be, wr_data,
        output rd_valid, rd_ch, rd_addr, dout_ready,
        input  rd_ready, dout_valid, dout_ch, dout_data
    );

    modport slave (
        input  wr_valid, wr_ch, wr_addr, wr_be, wr_data,
        input  rd_valid, rd_ch, rd_addr, dout_ready,
        output rd_ready, dout_valid, dout_ch, dout_data
    );
endinterface

// File: rtl/mc_sdp_bram.sv
// Multi-channel simple dual-port RAM with byte-enable writes and an elastic 1/2-stage read pipe.
// Define MC_SDP_BRAM_FWD_EN for write-first data on a same-address write/read collision.
module mc_sdp_bram #(
    parameter int unsigned RAM_WIDTH       = 128,
    parameter int unsigned BYTE_WIDTH      = 8,
    parameter int unsigned NUM_CH          = 4,
    parameter int unsigned CH_DEPTH        = 16,
    parameter string       RAM_PERFORMANCE = "LOW_LATENCY"
) (
    input  logic          clka,
    input  logic          rsta,
    mc_sdp_bram_if.slave  bus
);
    localparam int unsigned NB        = RAM_WIDTH / BYTE_WIDTH;
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned DEPTH     = NUM_CH * CH_DEPTH;
    localparam int unsigned PA_W      = $clog2(DEPTH);
    localparam bit          HIGH_PERF = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic [PA_W-1:0]      wr_pa_c;
    logic [PA_W-1:0]      rd_pa_c;
    logic                 wr_en_c;
    logic                 rd_ready_c;
    logic                 rd_acc_c;
    logic [RAM_WIDTH-1:0] rd_word_c;

    logic                 out_v;
    logic [CH_W-1:0]      out_ch;
    logic [RAM_WIDTH-1:0] out_d;

    // Channels are laid out back to back in one flat array.
    assign wr_pa_c  = PA_W'(bus.wr_ch) * PA_W'(CH_DEPTH) + PA_W'(bus.wr_addr);
    assign rd_pa_c  = PA_W'(bus.rd_ch) * PA_W'(CH_DEPTH) + PA_W'(bus.rd_addr);
    assign wr_en_c  = bus.wr_valid & ~rsta;
    assign rd_acc_c = bus.rd_valid & rd_ready_c;

    // Byte-lane write port; contents are never reset.
    always_ff @(posedge clka) begin
        if (wr_en_c) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.wr_be[i]) begin
                    mem[wr_pa_c][i*BYTE_WIDTH +: BYTE_WIDTH] <= bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word captured at acceptance; optional write-first merge on collision.
    always_comb begin
        rd_word_c = mem[rd_pa_c];
`ifdef MC_SDP_BRAM_FWD_EN
        if (wr_en_c && (wr_pa_c == rd_pa_c)) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (bus.wr_be[i]) begin
                    rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = bus.wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    generate
        if (HIGH_PERF) begin : g_hp
            logic                 s1_v;
            logic [CH_W-1:0]      s1_ch;
            logic [RAM_WIDTH-1:0] s1_d;
            logic                 out_adv_c;
            logic                 s1_free_c;

            // s1 refills whenever it is empty, even behind a stalled output stage.
            assign out_adv_c  = ~out_v | bus.dout_ready;
            assign s1_free_c  = ~s1_v | out_adv_c;
            assign rd_ready_c = ~rsta & s1_free_c;

            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    s1_v   <= 1'b0;
                    s1_ch  <= '0;
                    s1_d   <= '0;
                    out_v  <= 1'b0;
                    out_ch <= '0;
                    out_d  <= '0;
                end else begin
                    if (out_adv_c) begin
                        out_v <= s1_v;
                        if (s1_v) begin
                            out_ch <= s1_ch;
                            out_d  <= s1_d;
                        end
                    end
                    if (s1_free_c) begin
                        s1_v <= rd_acc_c;
                        if (rd_acc_c) begin
                            s1_ch <= bus.rd_ch;
                            s1_d  <= rd_word_c;
                        end
                    end
                end
            end
        end else begin : g_ll
            logic out_adv_c;

            assign out_adv_c  = ~out_v | bus.dout_ready;
            assign rd_ready_c = ~rsta & out_adv_c;

            always_ff @(posedge clka or posedge rsta) begin
                if (rsta) begin
                    out_v  <= 1'b0;
                    out_ch <= '0;
                    out_d  <= '0;
                end else if (out_adv_c) begin
                    out_v <= rd_acc_c;
                    if (rd_acc_c) begin
                        out_ch <= bus.rd_ch;
                        out_d  <= rd_word_c;
                    end
                end
            end
        end
    endgenerate

    assign bus.rd_ready   = rd_ready_c;
    assign bus.dout_valid = out_v;
    assign bus.dout_ch    = out_ch;
    assign bus.dout_data  = out_d;
endmodule

// File: tb/tb_mc_sdp_bram.sv
// Bench for mc_sdp_bram: LOW_LATENCY and HIGH_PERFORMANCE instances share one stimulus
// stream and are each checked against a queue-based response model.
module tb_mc_sdp_bram;
    localparam int unsigned RW  = 128;
    localparam int unsigned NB  = 16;
    localparam int unsigned CW  = 2;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEP = 64;

    typedef struct {
        logic [RW-1:0] d;
        logic [CW-1:0] ch;
        int            e;
    } rsp_t;

    logic clka;
    logic rsta;

    logic          wv;
    logic [CW-1:0] wch;
    logic [AW-1:0] wad;
    logic [NB-1:0] wbe;
    logic [RW-1:0] wdat;
    logic          rv;
    logic [CW-1:0] rch;
    logic [AW-1:0] rad;
    logic          drdy;

    logic [1:0]    o_rdy;
    logic [1:0]    o_v;
    logic [CW-1:0] o_ch [2];
    logic [RW-1:0] o_d  [2];

    logic [RW-1:0] ref_mem [DEP];
    rsp_t          q [2][$];
    int            cyc;
    int            n_chk;
    int            n_fail;

    mc_sdp_bram_if #(.RAM_WIDTH(RW), .BYTE_WIDTH(8), .NUM_CH(4), .CH_DEPTH(16)) bus_lo ();
    mc_sdp_bram_if #(.RAM_WIDTH(RW), .BYTE_WIDTH(8), .NUM_CH(4), .CH_DEPTH(16)) bus_hi ();

    mc_sdp_bram #(.RAM_WIDTH(RW), .BYTE_WIDTH(8), .NUM_CH(4), .CH_DEPTH(16),
                  .RAM_PERFORMANCE("LOW_LATENCY")) u_lo (.clka(clka), .rsta(rsta), .bus(bus_lo));
    mc_sdp_bram #(.RAM_WIDTH(RW), .BYTE_WIDTH(8), .NUM_CH(4), .CH_DEPTH(16),
                  .RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_hi (.clka(clka), .rsta(rsta), .bus(bus_hi));

    assign bus_lo.wr_valid = wv;    assign bus_hi.wr_valid = wv;
    assign bus_lo.wr_ch    = wch;   assign bus_hi.wr_ch    = wch;
    assign bus_lo.wr_addr  = wad;   assign bus_hi.wr_addr  = wad;
    assign bus_lo.wr_be    = wbe;   assign bus_hi.wr_be    = wbe;
    assign bus_lo.wr_data  = wdat;  assign bus_hi.wr_data  = wdat;
    assign bus_lo.rd_valid = rv;    assign bus_hi.rd_valid = rv;
    assign bus_lo.rd_ch    = rch;   assign bus_hi.rd_ch    = rch;
    assign bus_lo.rd_addr  = rad;   assign bus_hi.rd_addr  = rad;
    assign bus_lo.dout_ready = drdy; assign bus_hi.dout_ready = drdy;

    assign o_rdy = {bus_hi.rd_ready, bus_lo.rd_ready};
    assign o_v   = {bus_hi.dout_valid, bus_lo.dout_valid};
    assign o_ch[0] = bus_lo.dout_ch;   assign o_ch[1] = bus_hi.dout_ch;
    assign o_d[0]  = bus_lo.dout_data; assign o_d[1]  = bus_hi.dout_data;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int phys(input logic [CW-1:0] ch, input logic [AW-1:0] a);
        return int'(ch) * 16 + int'(a);
    endfunction

    function automatic logic [RW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: inputs already set; check both instances, advance the model, cross the edge.
    task automatic step();
        logic          exp_rdy;
        logic          ev;
        logic [RW-1:0] rword;
        rsp_t          r;
        string         pfx;
        int            rpa;
        int            wpa;
        #1;
        rpa   = phys(rch, rad);
        wpa   = phys(wch, wad);
        rword = ref_mem[rpa];
`ifdef MC_SDP_BRAM_FWD_EN
        if (wv && wpa == rpa)
            for (int b = 0; b < int'(NB); b++)
                if (wbe[b]) rword[b*8 +: 8] = wdat[b*8 +: 8];
`endif
        for (int i = 0; i < 2; i++) begin
            pfx     = (i == 0) ? "ll" : "hp";
            exp_rdy = (q[i].size() < (i + 1)) || drdy;
            check({pfx, "_rd_ready"}, RW'(o_rdy[i]), RW'(exp_rdy));
            ev = (q[i].size() > 0) && (cyc >= q[i][0].e + i);
            check({pfx, "_dout_valid"}, RW'(o_v[i]), RW'(ev));
            if (ev) begin
                check({pfx, "_dout_data"}, o_d[i], q[i][0].d);
                check({pfx, "_dout_ch"}, RW'(o_ch[i]), RW'(q[i][0].ch));
                if (drdy) void'(q[i].pop_front());
            end
            if (rv && exp_rdy) begin
                r.d = rword; r.ch = rch; r.e = cyc + 1;
                q[i].push_back(r);
            end
        end
        if (wv)
            for (int b = 0; b < int'(NB); b++)
                if (wbe[b]) ref_mem[wpa][b*8 +: 8] = wdat[b*8 +: 8];
        @(posedge clka);
        cyc++;
        #2;
    endtask

    task automatic idle();
        wv = 1'b0; rv = 1'b0; wbe = '0;
    endtask

    task automatic set_wr(input int ch, input int a, input logic [NB-1:0] be, input logic [RW-1:0] d);
        wv = 1'b1; wch = CW'(ch); wad = AW'(a); wbe = be; wdat = d;
    endtask

    task automatic set_rd(input int ch, input int a);
        rv = 1'b1; rch = CW'(ch); rad = AW'(a);
    endtask

    task automatic drain();
        idle(); drdy = 1'b1;
        repeat (4) step();
    endtask

    // Async reset pulse placed between edges; write/read attempts during it must be ignored.
    task automatic reset_pulse(input int cycles);
        rsta = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_dout_valid", RW'(o_v[i]), '0);
            check("rst_dout_data", o_d[i], '0);
            check("rst_dout_ch", RW'(o_ch[i]), '0);
            q[i].delete();
        end
        set_wr(2, 5, '1, rnd128());
        set_rd(2, 5);
        repeat (cycles) begin
            @(posedge clka);
            cyc++;
        end
        #1;
        rsta = 1'b0;
        idle();
    endtask

    initial begin
        logic [RW-1:0] pat;
        n_chk = 0; n_fail = 0; cyc = 0;
        rsta = 1'b1; drdy = 1'b1;
        wch = '0; wad = '0; wdat = '0; rch = '0; rad = '0;
        idle();
        for (int i = 0; i < int'(DEP); i++) ref_mem[i] = '0;
        repeat (3) @(posedge clka);
        #2;
        for (int i = 0; i < 2; i++) begin
            check("init_dout_valid", RW'(o_v[i]), '0);
            check("init_dout_data", o_d[i], '0);
        end
        rsta = 1'b0;

        for (int a = 0; a < int'(DEP); a++) begin
            set_wr(a / 16, a % 16, '1, '0);
            step();
        end
        drain();

        // ch2/addr5 write then read
        pat = {16{8'hA5}};
        set_wr(2, 5, '1, pat); step();
        idle(); set_rd(2, 5); step();
        idle();
        check("ll_a5_valid", RW'(o_v[0]), RW'(1'b1));
        check("ll_a5_data", o_d[0], pat);
        check("ll_a5_ch", RW'(o_ch[0]), RW'(2));
        step();
        drain();

        // single byte-lane update
        set_wr(1, 3, '1, {16{8'h11}}); step();
        set_wr(1, 3, 16'h0001, '1); step();
        idle(); set_rd(1, 3); step();
        idle();
        check("ll_be_data", o_d[0], {{15{8'h11}}, 8'hFF});
        step();
        drain();

        // stalled output: HIGH_PERFORMANCE holds two, then releases in order
        drdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_rd(k, k + 7);
            if (k == 2) begin
                #1;
                check("hp_full_rd_ready", RW'(o_rdy[1]), '0);
            end
            step();
        end
        idle();
        step();
        drdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_rd(3 - k, k);
            step();
        end
        drain();

        // collision: read-first or write-first depending on build
        set_wr(3, 9, '1, {8{16'h1234}}); step();
        set_wr(3, 9, '1, {8{16'hBEEF}}); set_rd(3, 9); step();
        idle();
`ifdef MC_SDP_BRAM_FWD_EN
        check("ll_collide", o_d[0], {8{16'hBEEF}});
`else
        check("ll_collide", o_d[0], {8{16'h1234}});
`endif
        step();
        drain();

        // channel boundary: address 15 vs 16
        set_wr(0, 15, '1, {4{32'h0F0F_0015}}); step();
        set_wr(1, 0, '1, {4{32'h1010_0016}}); step();
        idle(); set_rd(0, 15); step();
        set_rd(1, 0); step();
        drain();

        // reset with reads in flight; memory survives
        drdy = 1'b0;
        set_rd(2, 5); step();
        set_rd(0, 15); step();
        reset_pulse(3);
        drdy = 1'b1;
        repeat (3) step();
        set_rd(2, 5); step();
        set_rd(1, 0); step();
        drain();

        // random traffic over a small address window to provoke collisions
        for (int n = 0; n < 3000; n++) begin
            wv   = ($urandom_range(0, 99) < 60);
            wch  = CW'($urandom_range(0, 3));
            wad  = AW'($urandom_range(0, 3) + (($urandom_range(0, 3) == 0) ? 12 : 0));
            wbe  = NB'($urandom);
            wdat = rnd128();
            rv   = ($urandom_range(0, 99) < 70);
            rch  = ($urandom_range(0, 1) == 0) ? wch : CW'($urandom_range(0, 3));
            rad  = ($urandom_range(0, 1) == 0) ? wad : AW'($urandom_range(0, 15));
            drdy = ($urandom_range(0, 99) < 65);
            step();
            if (n == 1500) reset_pulse(2);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
